cnt_seq_ctrl: RTL and testbench
===============================

CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4, meaning number of clk cycles per count step in RUN (legal range 2..255).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn_start  input  1  start/resume request, level, synchronous to clk.
REQ-005 btn_stop  input  1  pause/abort request, level, synchronous to clk.
REQ-006 btn_mode  input  1  even/odd mode toggle request, level, synchronous to clk.
REQ-007 sel_dir  input  1  requested direction: 1 = up, 0 = down.
REQ-008 pingpong  input  1  1 = reverse direction at the range ends instead of wrapping.
REQ-009 cnt_rst  output  1  one-cycle load strobe to the counter datapath.
REQ-010 cen  output  1  one-cycle step enable to the counter datapath.
REQ-011 dir  output  1  current step direction to the datapath.
REQ-012 eo  output  1  current parity mode: 1 = odd values, 0 = even values.
REQ-013 count  output  4  shadow of the datapath value after the most recent strobe.
REQ-014 state  output  2  FSM state: IDLE=00, LOAD=01, RUN=10, HOLD=11.

Function
REQ-015 Each button SHALL be rising-edge detected against a registered copy; an event is btn high this cycle and low the previous cycle.
REQ-016 IDLE: btn_mode event SHALL toggle eo; btn_start event SHALL go to LOAD; btn_stop is ignored.
REQ-017 btn_mode events SHALL be ignored in every state other than IDLE.
REQ-018 LOAD: lasts exactly one cycle; cnt_rst=1; count <= {3'b000,eo}; dir <= sel_dir; prescaler <= 0; next state RUN.
REQ-019 RUN: prescaler SHALL count 0..PRESCALE-1 and wrap; on the cycle it equals PRESCALE-1, cen=1 for that cycle only and count updates that edge.
REQ-020 Step arithmetic SHALL be 4-bit modulo 16: up = count+2, down = count-2; the LSB, and so parity, never changes.
REQ-021 pingpong=0: wrap-around is allowed (14 up -> 0, 15 up -> 1, 0 down -> 14, 1 down -> 15).
REQ-022 pingpong=1: on a step that would wrap (up from 14/15, down from 0/1), dir SHALL flip on that edge and the step SHALL apply in the new direction (14 -> 12, 1 -> 3); cen still pulses.
REQ-023 RUN: btn_stop event SHALL go to HOLD, with no cen on that cycle even if the prescaler is at terminal count.
REQ-024 HOLD: prescaler and count frozen; cen=0; btn_start event SHALL return to RUN with dir <= sel_dir (unless pingpong=1, in which case dir is kept) and the prescaler resumes from its held value.
REQ-025 HOLD: btn_stop event SHALL go to IDLE; count and eo are retained.
REQ-026 Simultaneous start and stop events in RUN or HOLD: stop SHALL win.
REQ-027 cnt_rst and cen SHALL never both be 1 in the same cycle.
REQ-028 count SHALL change only on cycles where cnt_rst or cen is 1.

Reset
REQ-029 With rst=1: state=IDLE, cnt_rst=0, cen=0, dir=1, eo=0, count=0, prescaler=0, and button history registers=0.
REQ-030 rst SHALL override all other inputs and take effect from any state, including mid-LOAD and mid-RUN; the first edge after release is evaluated from IDLE.

Verification (PRESCALE=4)
REQ-031 Reset, start with eo=0, sel_dir=1, pingpong=0 -> state 01 for 1 cycle with cnt_rst=1 and count=0; then cen every 4th cycle; count 2,4,...,14,0.
REQ-032 Mode event in IDLE, then start, sel_dir=0 -> count=1 after LOAD; steps 15,13,11; mode events during RUN leave eo=1.
REQ-033 pingpong=1, eo=0, up -> count 10,12,14,12,10 with dir falling to 0 on the 14->12 edge; at 2->0->2, dir rises to 1.
REQ-034 Stop on a prescaler terminal cycle -> no cen, HOLD; 20 idle cycles with no count change; start -> next cen after the remaining prescale cycles; second stop from HOLD -> IDLE, count retained.
REQ-035 Start and stop asserted the same cycle in RUN -> HOLD; in IDLE -> LOAD.
REQ-036 rst asserted mid-RUN at count=6 -> next cycle IDLE, count=0, eo=0, dir=1, cen=0, and no cnt_rst pulse.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: button-driven sequencer for an even/odd step-by-two counter datapath.
module cnt_seq_ctrl #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_mode,
    input  logic       sel_dir,
    input  logic       pingpong,
    output logic       cnt_rst,
    output logic       cen,
    output logic       dir,
    output logic       eo,
    output logic [3:0] count,
    output logic [1:0] state
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] HOLD = 2'b11;
    localparam logic [7:0] TC   = 8'(PRESCALE - 1);

    logic       start_q, stop_q, mode_q;
    logic       start_ev, stop_ev, mode_ev;
    logic [7:0] presc;
    logic       flip, ndir;
    logic [3:0] nxt;

    assign start_ev = btn_start & ~start_q;
    assign stop_ev  = btn_stop & ~stop_q;
    assign mode_ev  = btn_mode & ~mode_q;

    // A stop event pre-empts a step that would otherwise land on the same cycle.
    assign cen     = !rst && state == RUN && presc == TC && !stop_ev;
    assign cnt_rst = !rst && state == LOAD;

    // Pingpong bounces off the ends: reverse first, then step in the new direction.
    assign flip = pingpong && (dir ? count[3:1] == 3'b111 : count[3:1] == 3'b000);
    assign ndir = dir ^ flip;
    assign nxt  = ndir ? count + 4'd2 : count - 4'd2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir     <= 1'b1;
            eo      <= 1'b0;
            count   <= 4'd0;
            presc   <= 8'd0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            start_q <= btn_start;
            stop_q  <= btn_stop;
            mode_q  <= btn_mode;
            case (state)
                IDLE: begin
                    if (mode_ev) eo <= ~eo;
                    if (start_ev) state <= LOAD;
                end
                LOAD: begin
                    count <= {3'b000, eo};
                    dir   <= sel_dir;
                    presc <= 8'd0;
                    state <= RUN;
                end
                RUN: begin
                    if (stop_ev) state <= HOLD;
                    else begin
                        presc <= presc == TC ? 8'd0 : presc + 8'd1;
                        if (cen) begin
                            count <= nxt;
                            dir   <= ndir;
                        end
                    end
                end
                default: begin
                    if (stop_ev) state <= IDLE;
                    else if (start_ev) begin
                        state <= RUN;
                        if (!pingpong) dir <= sel_dir;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: directed table and hand sequences for cnt_seq_ctrl at PRESCALE=4.
module tb_cnt_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst, btn_start, btn_stop, btn_mode, sel_dir, pingpong;
    logic       cnt_rst, cen, dir, eo;
    logic [3:0] count;
    logic [1:0] state;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       mon_en = 1'b0;
    logic       prev_strobe = 1'b1;
    logic [3:0] prev_count = 4'd0;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    typedef struct packed {
        logic       r, st, sp, md, sd, pp;
        logic [1:0] e_state;
        logic       e_cr, e_cen, e_dir, e_eo;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    cnt_seq_ctrl #(.PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
        .btn_mode(btn_mode), .sel_dir(sel_dir), .pingpong(pingpong),
        .cnt_rst(cnt_rst), .cen(cen), .dir(dir), .eo(eo), .count(count), .state(state)
    );

    always #5 clk = ~clk;

    // Invariants: strobes are exclusive, and count only moves after a strobe or reset.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (cnt_rst && cen) begin
                n_err++;
                $display("FAIL strobe_overlap cnt_rst=%0b cen=%0b want not both", cnt_rst, cen);
            end
            n_cmp++;
            if (!prev_strobe && count !== prev_count) begin
                n_err++;
                $display("FAIL count_hold got %0h want %0h", count, prev_count);
            end
        end
        prev_strobe = cnt_rst | cen | rst;
        prev_count  = count;
    end

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic cr, input logic ce,
                           input logic d, input logic e, input logic [3:0] c);
        chk({tag, ".state"}, {2'b00, state}, {2'b00, st});
        chk({tag, ".cnt_rst"}, {3'b000, cnt_rst}, {3'b000, cr});
        chk({tag, ".cen"}, {3'b000, cen}, {3'b000, ce});
        chk({tag, ".dir"}, {3'b000, dir}, {3'b000, d});
        chk({tag, ".eo"}, {3'b000, eo}, {3'b000, e});
        chk({tag, ".count"}, count, c);
    endtask

    task automatic cyc(input logic r, input logic st, input logic sp, input logic md,
                       input logic sd, input logic pp);
        @(posedge clk);
        #1;
        rst = r; btn_start = st; btn_stop = sp; btn_mode = md; sel_dir = sd; pingpong = pp;
        @(negedge clk);
    endtask

    task automatic period(input logic [3:0] c, input logic d, input logic e,
                          input logic sd, input logic pp, input logic md);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, md & i[0], sd, pp);
            chk_out($sformatf("run_c%0h_p%0d", c, i), S_RUN, 1'b0, i == 3, d, e, c);
        end
    endtask

    initial begin
        tbl[0]  = vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[1]  = vec_t'{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[2]  = vec_t'{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, S_LOAD, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[3]  = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[4]  = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[5]  = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[6]  = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[7]  = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[8]  = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[9]  = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[10] = vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN,  1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        rst = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_mode = 1'b0; sel_dir = 1'b1; pingpong = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        mon_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].sd, tbl[i].pp);
            chk_out($sformatf("tbl%0d", i), tbl[i].e_state, tbl[i].e_cr, tbl[i].e_cen,
                    tbl[i].e_dir, tbl[i].e_eo, tbl[i].e_cnt);
        end
        for (int k = 2; k <= 7; k++) period(4'(2 * k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_out("wrap0", S_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("stop_tc", S_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("hold_in", S_HOLD, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_out("hold_idle", S_HOLD, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("resume_req", S_HOLD, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("resume_tc", S_RUN, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("resume_p0", S_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("both_run", S_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("both_hold", S_HOLD, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_out("stop2_req", S_HOLD, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("stop2_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("mode_req", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("mode_set", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("odd_start", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("odd_load", S_LOAD, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
        period(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        period(4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        period(4'd13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        period(4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("rst_a", S_RUN, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("rst_a_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("rst_a_load", S_LOAD, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k <= 2; k++) period(4'(2 * k), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_out("pre_rst6", S_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("rst_tc", S_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("rst_b_idle", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("pp_start", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("pp_load", S_LOAD, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k <= 7; k++) period(4'(2 * k), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        period(4'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        period(4'd10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_out("pp_stop", S_RUN, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("pp_hold", S_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("pp_resume", S_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
        for (int k = 4; k >= 0; k--) period(4'(2 * k), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        period(4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
